l2_bank_responder: RTL and testbench
====================================

# l2_bank_responder

Memory-side responder for one slave port of the L2 crossbar: accepts the bank request stream (request, word address, write-enable, data, byte-enable, master ID) and returns read data, response valid and the echoed ID after a fixed pipelined latency. Contains the bank storage array, a post-reset zero-initialisation sequencer and an ID/valid delay line. One instance per crossbar slave port.

## Interface
- ADDR_MEM_WIDTH, 12, word address width; bank depth = 2**ADDR_MEM_WIDTH words
- DATA_WIDTH, 64, data word width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, 9, one-hot master ID width
- RD_LAT, 1, response latency in cycles, legal 1..4

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  request
- data_add_i  in  ADDR_MEM_WIDTH  word address
- data_wen_i  in  1  1 = read, 0 = write
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables, bit b covers bits 8b+7:8b
- data_ID_i  in  ID_WIDTH  requester ID
- err_inject_i  in  1  invert stored parity on this write (macro builds only)
- data_gnt_o  out  1  grant; 0 during init
- data_r_valid_o  out  1  response valid, one-cycle pulse
- data_r_rdata_o  out  DATA_WIDTH  read data
- data_r_ID_o  out  ID_WIDTH  echoed ID
- data_r_err_o  out  1  parity error, qualified by data_r_valid_o
- init_done_o  out  1  zero-initialisation finished

## Operation
- FSM states INIT, RUN. Reset enters INIT, init counter = 0.
- INIT: each cycle writes 0 (all bytes, correct parity) at counter address, counter increments; after writing address 2**ADDR_MEM_WIDTH-1 -> RUN. data_gnt_o = 0; requests ignored, no response generated.
- RUN: data_gnt_o = 1 every cycle; init_done_o = 1; one request accepted per cycle when data_req_i = 1.
- Write (wen=0): only bytes with be=1 updated; others unchanged. be = 0 is a legal no-op write that still responds.
- Every accepted request, read or write, produces exactly one response carrying its ID. Write responses: data_r_rdata_o = 0, data_r_err_o = 0.
- Read returns array contents at acceptance edge, including a write accepted in the immediately preceding cycle (no forwarding needed; write lands at its acceptance edge).
- Delay line: RD_LAT stages of {valid, ID, is_read}; read data registered at stage 1 and carried with it. Responses never reorder or merge.
- Reset mid-operation: pipeline valids cleared immediately, pending responses dropped, FSM returns to INIT and re-zeroes array.

## Timing
- Request accepted at edge t (data_req_i & data_gnt_o) -> data_r_valid_o high during cycle t+RD_LAT, for one cycle.
- Full throughput: back-to-back requests give back-to-back responses.
- Init duration: exactly 2**ADDR_MEM_WIDTH cycles after reset release; data_gnt_o and init_done_o rise together in the first RUN cycle.
- Reset values: data_gnt_o 0, data_r_valid_o 0, data_r_rdata_o 0, data_r_ID_o 0, data_r_err_o 0, init_done_o 0.
- data_r_rdata_o, data_r_ID_o hold last value when data_r_valid_o = 0.

## Configuration
- L2_BANK_PARITY_EN defined: one even-parity bit stored per byte, written with each enabled byte (inverted when err_inject_i = 1 on that write). On read response, data_r_err_o = 1 if any byte's stored parity mismatches its data.
- Not defined: no parity storage; err_inject_i ignored; data_r_err_o tied 0.

## Test plan
- Reset release with ADDR_MEM_WIDTH=4 -> data_gnt_o=0 for 16 cycles, then gnt=init_done_o=1; read of address 0xF returns 0.
- Write 0x1122334455667788 to addr 3, be=0xFF, ID=0x004; read addr 3 next cycle, ID=0x010 -> two responses on consecutive cycles, IDs 0x004 then 0x010, read data 0x1122334455667788.
- Partial write be=0x0F data 0xAAAAAAAAAAAAAAAA over previous value -> read returns 0x11223344AAAAAAAA.
- RD_LAT=3, 8 back-to-back alternating reads/writes -> 8 valid pulses starting exactly 3 cycles after first acceptance, IDs in order, no gaps.
- Assert rst_n low with 2 responses in flight -> no response emitted, outputs at reset values, init restarts.
- With L2_BANK_PARITY_EN: write addr 5 with err_inject_i=1, read addr 5 -> data_r_err_o=1 with data_r_valid_o; clean rewrite then read -> data_r_err_o=0.

Source files
------------

// File: rtl/l2_bank_responder.sv
// L2 crossbar slave-port responder: bank storage, post-reset zero-initialisation and a fixed-latency response pipeline.
// Optional per-byte even parity with error injection is enabled by defining L2_BANK_PARITY_EN.
//
// state | meaning
// INIT  | zero the array one word per cycle, grant low, requests ignored
// RUN   | grant high, one request accepted per cycle
module l2_bank_responder #(
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 9,
    parameter int RD_LAT         = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
    input  logic                      data_wen_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    input  logic [BE_WIDTH-1:0]       data_be_i,
    input  logic [ID_WIDTH-1:0]       data_ID_i,
    input  logic                      err_inject_i,
    output logic                      data_gnt_o,
    output logic                      data_r_valid_o,
    output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
    output logic [ID_WIDTH-1:0]       data_r_ID_o,
    output logic                      data_r_err_o,
    output logic                      init_done_o
);

    localparam int DEPTH = 2 ** ADDR_MEM_WIDTH;
    localparam int LAST  = RD_LAT - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_MEM_WIDTH-1:0] init_cnt_q;
    logic                      gnt;
    logic                      accept;
    logic                      do_write;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic                      rd_err;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    logic [RD_LAT-1:0]         v_q;
    logic [RD_LAT-1:0]         rd_q;
    logic [RD_LAT-1:0]         err_q;
    logic [ID_WIDTH-1:0]       id_q  [RD_LAT];
    logic [DATA_WIDTH-1:0]     dat_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        case (state_q)
            INIT: if (init_cnt_q == '1) state_d = RUN;
            RUN:  gnt = 1'b1;
            default: state_d = INIT;
        endcase
    end

    assign data_gnt_o  = gnt;
    assign init_done_o = gnt;
    assign accept      = data_req_i & gnt;
    assign do_write    = accept & ~data_wen_i;

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[init_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BE_WIDTH; b++)
                if (data_be_i[b]) mem[data_add_i][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
    end

    assign rd_word = mem[data_add_i];

`ifdef L2_BANK_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [DEPTH];
    logic [BE_WIDTH-1:0] wr_par;
    logic [BE_WIDTH-1:0] rd_par_calc;

    always_comb begin
        wr_par      = '0;
        rd_par_calc = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            wr_par[b]      = ^data_wdata_i[8*b +: 8] ^ err_inject_i;
            rd_par_calc[b] = ^rd_word[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            par_mem[init_cnt_q] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BE_WIDTH; b++)
                if (data_be_i[b]) par_mem[data_add_i][b] <= wr_par[b];
        end
    end

    assign rd_err = |(rd_par_calc ^ par_mem[data_add_i]);
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject_i;
    assign rd_err            = 1'b0;
`endif

    // Payload in each stage only moves with a valid token, so the last stage holds its value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            rd_q  <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                id_q[i]  <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            v_q[0] <= accept;
            if (accept) begin
                id_q[0]  <= data_ID_i;
                rd_q[0]  <= data_wen_i;
                dat_q[0] <= rd_word;
                err_q[0] <= data_wen_i & rd_err;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    id_q[i]  <= id_q[i-1];
                    rd_q[i]  <= rd_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    assign data_r_valid_o = v_q[LAST];
    assign data_r_ID_o    = id_q[LAST];
    assign data_r_rdata_o = rd_q[LAST] ? dat_q[LAST] : '0;
    assign data_r_err_o   = err_q[LAST];

endmodule

// File: tb/tb_l2_bank_responder.sv
// Randomised bench for l2_bank_responder: two instances (latency 1 and 3) driven in parallel and checked against a word/byte-level bank model.
module tb_l2_bank_responder;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int IW = 9;
    localparam int NWORDS = 16;

    typedef struct {
        int          due;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [AW-1:0] add = '0;
    logic          wen = 1'b1;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be = '0;
    logic [IW-1:0] id = '0;
    logic          inj = 1'b0;

    logic          gnt1, v1, e1, done1;
    logic [DW-1:0] d1;
    logic [IW-1:0] id1;
    logic          gnt3, v3, e3, done3;
    logic [DW-1:0] d3;
    logic [IW-1:0] id3;

    always #5 clk = ~clk;

    l2_bank_responder #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_ID_i(id), .err_inject_i(inj),
        .data_gnt_o(gnt1), .data_r_valid_o(v1), .data_r_rdata_o(d1), .data_r_ID_o(id1),
        .data_r_err_o(e1), .init_done_o(done1)
    );

    l2_bank_responder #(.ADDR_MEM_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_ID_i(id), .err_inject_i(inj),
        .data_gnt_o(gnt3), .data_r_valid_o(v3), .data_r_rdata_o(d3), .data_r_ID_o(id3),
        .data_r_err_o(e3), .init_done_o(done3)
    );

    rsp_t          q1[$];
    rsp_t          q3[$];
    logic [DW-1:0] mmem [NWORDS];
    logic [BW-1:0] mbad [NWORDS];
    logic [IW-1:0] last_id1, last_id3;
    logic [DW-1:0] last_d1, last_d3;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            since = 0;
    logic          gnt_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < NWORDS; a++) begin
            mmem[a] = '0;
            mbad[a] = '0;
        end
        q1.delete();
        q3.delete();
        last_id1 = '0; last_id3 = '0;
        last_d1  = '0; last_d3  = '0;
    endtask

    task automatic check_inst(input string nm, input logic v, input logic [IW-1:0] oid,
                              input logic [DW-1:0] od, input logic oe, input logic g, input logic dn,
                              input bit exp_v, input rsp_t h, input logic [IW-1:0] lid, input logic [DW-1:0] ld);
        chk({nm, ".gnt"}, g, gnt_exp);
        chk({nm, ".init_done"}, dn, gnt_exp);
        chk({nm, ".valid"}, v, exp_v);
        if (exp_v) begin
            chk({nm, ".id"}, oid, h.id);
            chk({nm, ".rdata"}, od, h.data);
            chk({nm, ".err"}, oe, h.err);
        end else begin
            chk({nm, ".id_hold"}, oid, lid);
            chk({nm, ".rdata_hold"}, od, ld);
        end
    endtask

    task automatic check_outputs();
        rsp_t h;
        bit   ev;
        h  = '{0, '0, '0, 1'b0};
        ev = (q1.size() > 0) && (q1[0].due == cyc);
        if (ev) h = q1[0];
        check_inst("lat1", v1, id1, d1, e1, gnt1, done1, ev, h, last_id1, last_d1);
        if (ev) begin
            last_id1 = h.id; last_d1 = h.data;
            void'(q1.pop_front());
        end
        h  = '{0, '0, '0, 1'b0};
        ev = (q3.size() > 0) && (q3[0].due == cyc);
        if (ev) h = q3[0];
        check_inst("lat3", v3, id3, d3, e3, gnt3, done3, ev, h, last_id3, last_d3);
        if (ev) begin
            last_id3 = h.id; last_d3 = h.data;
            void'(q3.pop_front());
        end
    endtask

    task automatic model_accept(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                                input logic [BW-1:0] b, input logic [IW-1:0] i, input logic ij);
        rsp_t r;
        r.id = i;
        if (w) begin
            r.data = mmem[a];
`ifdef L2_BANK_PARITY_EN
            r.err = |mbad[a];
`else
            r.err = 1'b0;
`endif
        end else begin
            for (int k = 0; k < BW; k++)
                if (b[k]) begin
                    mmem[a][8*k +: 8] = wd[8*k +: 8];
                    mbad[a][k]        = ij;
                end
            r.data = '0;
            r.err  = 1'b0;
        end
        r.due = cyc + 1;
        q1.push_back(r);
        r.due = cyc + 3;
        q3.push_back(r);
    endtask

    task automatic cycle(input logic r, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input logic [BW-1:0] b, input logic [IW-1:0] i, input logic ij);
        @(negedge clk);
        cyc++;
        since++;
        gnt_exp = (since >= NWORDS);
        check_outputs();
        req = r; add = a; wen = w; wdata = wd; be = b; id = i; inj = ij;
        if (r && gnt_exp) model_accept(a, w, wd, b, i, ij);
    endtask

    task automatic rand_cycle(input int req_pct);
        logic [DW-1:0] wd;
        wd = {$urandom(), $urandom()};
        cycle(($urandom_range(99, 0) < req_pct), AW'($urandom_range(NWORDS - 1, 0)), 1'($urandom()),
              wd, BW'($urandom()), IW'(1) << $urandom_range(IW - 1, 0), ($urandom_range(7, 0) == 0));
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b1, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("rst.gnt", {gnt3, gnt1}, 2'b00);
        chk("rst.init_done", {done3, done1}, 2'b00);
        chk("rst.valid", {v3, v1}, 2'b00);
        chk("rst.err", {e3, e1}, 2'b00);
        chk("rst.id", {id3, id1}, '0);
        chk("rst.rdata1", d1, '0);
        chk("rst.rdata3", d3, '0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        since = 0;
    endtask

    initial begin
        model_clear();
        do_reset();
        // requests during init must be ignored
        repeat (20) rand_cycle(80);
        repeat (3) idle();

        cycle(1'b1, 4'hF, 1'b1, '0, '0, 9'h001, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 64'h1122334455667788, 8'hFF, 9'h004, 1'b0);
        cycle(1'b1, 4'h3, 1'b1, '0, '0, 9'h010, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 9'h020, 1'b0);
        cycle(1'b1, 4'h3, 1'b1, '0, '0, 9'h040, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 9'h080, 1'b0);
        cycle(1'b1, 4'h3, 1'b1, '0, '0, 9'h100, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 64'h0102030405060708, 8'hFF, 9'h002, 1'b1);
        cycle(1'b1, 4'h5, 1'b1, '0, '0, 9'h008, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 64'h0102030405060708, 8'hFF, 9'h002, 1'b0);
        cycle(1'b1, 4'h5, 1'b1, '0, '0, 9'h008, 1'b0);
        repeat (4) idle();

        for (int k = 0; k < 8; k++)
            cycle(1'b1, AW'(k), 1'(k % 2), {32'hC0DE0000, 32'(k)}, 8'hFF, IW'(1) << k, 1'b0);
        repeat (4) idle();

        repeat (300) rand_cycle(85);

        cycle(1'b1, 4'h7, 1'b0, 64'hDEADBEEFCAFEF00D, 8'hFF, 9'h001, 1'b0);
        cycle(1'b1, 4'h7, 1'b1, '0, '0, 9'h002, 1'b0);
        do_reset();
        repeat (20) rand_cycle(50);
        cycle(1'b1, 4'h7, 1'b1, '0, '0, 9'h004, 1'b0);
        repeat (150) rand_cycle(85);
        repeat (5) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
